// File: rtl/banco_reg_sb.sv
// banco_reg_sb: pipelined register file with power-on/soft clear sequencer,
// write-to-read bypass, optional hardwired-zero register 0 and a
// pending-write scoreboard used by the hazard unit to stall decode.
// Reads and busy flags are combinational; writes, reservations and the
// clear sequencer update on the rising edge of clk.

module banco_reg_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regW,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic              resv,
    input  logic [ADDR_W-1:0] resvReg,
    output logic              busy1,
    output logic              busy2,
    output logic              ready
);

    localparam int                NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam bit                ZERO_EN  = (ZERO_REG != 0);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              ready_r;
    logic [DATA_W-1:0] mem_r [NREGS];
    logic [NREGS-1:0]  pend_r;

    logic              running_s;
    logic              writeEn_s;
    logic              resvEn_s;
    logic              hit1_s;
    logic              hit2_s;
    logic [DATA_W-1:0] readData1_s;
    logic [DATA_W-1:0] readData2_s;
    logic              busy1_s;
    logic              busy2_s;

    // True when idx names the hardwired-zero register (only if enabled).
    function automatic logic isZeroReg(input logic [ADDR_W-1:0] idx);
        return ZERO_EN && (idx == '0);
    endfunction

    // Qualify writes and reservations: only in RUN, never to a hardwired zero.
    always_comb begin
        running_s = (state_r == RUN);
        writeEn_s = running_s && regW && !isZeroReg(writeReg);
        resvEn_s  = running_s && resv && !isZeroReg(resvReg);
        hit1_s    = writeEn_s && (writeReg == readReg1);
        hit2_s    = writeEn_s && (writeReg == readReg2);
    end

    // Read port 1: zero register, then same-cycle bypass, then storage.
    always_comb begin
        readData1_s = '0;
        busy1_s     = 1'b0;
        if (!running_s) begin
            readData1_s = '0;
            busy1_s     = 1'b0;
        end else if (isZeroReg(readReg1)) begin
            readData1_s = '0;
            busy1_s     = 1'b0;
        end else if (hit1_s) begin
            // Writeback in this cycle resolves the hazard through the bypass.
            readData1_s = writeData;
            busy1_s     = 1'b0;
        end else begin
            readData1_s = mem_r[readReg1];
            busy1_s     = pend_r[readReg1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        readData2_s = '0;
        busy2_s     = 1'b0;
        if (!running_s) begin
            readData2_s = '0;
            busy2_s     = 1'b0;
        end else if (isZeroReg(readReg2)) begin
            readData2_s = '0;
            busy2_s     = 1'b0;
        end else if (hit2_s) begin
            readData2_s = writeData;
            busy2_s     = 1'b0;
        end else begin
            readData2_s = mem_r[readReg2];
            busy2_s     = pend_r[readReg2];
        end
    end

    assign readData1 = readData1_s;
    assign readData2 = readData2_s;
    assign busy1     = busy1_s;
    assign busy2     = busy2_s;
    assign ready     = ready_r;

    // Clear sequencer FSM: walk ptr over every entry, then enter RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= CLEAR;
            ptr_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    ptr_r <= ptr_r + PTR_ONE;
                    if (ptr_r == PTR_LAST) begin
                        state_r <= RUN;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= CLEAR;
                        ready_r <= 1'b0;
                    end
                end
                RUN: begin
                    state_r <= RUN;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= CLEAR;
                    ptr_r   <= '0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage: zero-fill during CLEAR, WB writes during RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == CLEAR) begin
                mem_r[ptr_r] <= '0;
            end else if (writeEn_s) begin
                mem_r[writeReg] <= writeData;
            end
        end
    end

    // Scoreboard: writeback clears, reservation sets; set is applied last so
    // a newer producer issued in the same cycle keeps the register pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= '0;
        end else if (running_s) begin
            if (writeEn_s) begin
                pend_r[writeReg] <= 1'b0;
            end
            if (resvEn_s) begin
                pend_r[resvReg] <= 1'b1;
            end
        end else begin
            pend_r <= '0;
        end
    end

endmodule

// File: doc/banco_reg_sb.md
Name: banco_reg_sb

Overview:
- Parametrised successor to the single-cycle MIPS register file, for the pipelined datapath.
- Adds:
  - a synchronous-reset clear sequencer;
  - write-to-read bypass for decode-stage reads;
  - hardwired-zero register 0 (optional);
  - a pending-write scoreboard so the hazard unit can stall on in-flight producers.
- Sits between the ID stage (reads, reservations) and the WB stage (writes).

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W entries.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and reservations; when 0 it is an ordinary register.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- regW  input  1  write enable from WB.
- writeReg  input  ADDR_W  write index.
- writeData  input  DATA_W  write data.
- readReg1  input  ADDR_W  read port 1 index.
- readReg2  input  ADDR_W  read port 2 index.
- readData1  output  DATA_W  read port 1 data (combinational).
- readData2  output  DATA_W  read port 2 data (combinational).
- resv  input  1  reserve destination at issue (marks a write pending).
- resvReg  input  ADDR_W  index to reserve.
- busy1  output  1  readReg1 has an unresolved pending write.
- busy2  output  1  readReg2 has an unresolved pending write.
- ready  output  1  clear sequence finished; block accepts traffic.

Behaviour:
- FSM, two states:
  - CLEAR: entered on rst=1 from any state, including mid-operation. Each cycle writes 0 to mem[ptr], then ptr <= ptr+1. In the cycle ptr==NREGS-1, transition to RUN. ptr resets to 0.
  - RUN: normal operation; rst returns the FSM to CLEAR.
- Clear timing: rst deasserted after cycle 0 → ready=0 for exactly NREGS cycles, ready=1 from cycle NREGS onward.
- Reset values:
  - ready=0, ptr=0.
  - All pend bits 0, so busy1=busy2=0.
  - readData1=readData2=0 for the whole CLEAR state.
- Inputs ignored during CLEAR: regW, resv.
- Write (RUN only): if regW=1, mem[writeReg] <= writeData at the rising edge. Dropped if ZERO_REG=1 and writeReg==0.
- Read (RUN only), evaluated per port N in priority order:
  1. ZERO_REG=1 and readRegN==0 → readDataN = 0.
  2. Bypass: regW=1 and writeReg==readRegN (and the write is not dropped) → readDataN = writeData in the same cycle.
  3. Otherwise readDataN = mem[readRegN].
- Scoreboard (RUN only): pend[NREGS] register bits.
  - resv=1 sets pend[resvReg] at the edge.
  - regW=1 clears pend[writeReg] at the edge.
  - Same index set and cleared in the same cycle → set wins (a newer producer has been issued).
  - Reservations of reg 0 are ignored when ZERO_REG=1.
- busyN = pend[readRegN] AND NOT (regW AND writeReg==readRegN). A writeback in the current cycle resolves the hazard through the bypass. busyN=0 for reg 0 when ZERO_REG=1.
- Reserving an already-pending register leaves it pending: single bit, no count.
- Both read ports may address the same register: identical data and busy on both.
- Latency: reads and busy are 0-cycle combinational; writes and reservations are visible on the next cycle.
- No X on any output after the first rst cycle.

Test Plan:
- rst=1 for 1 cycle, then 0 → ready=0 for 32 cycles, ready=1 at cycle 32; readData1/readData2 = 0 for readReg 0..31; busy1=busy2=0.
- RUN: regW=1, writeReg=5, writeData=0xDEADBEEF, readReg1=5 → readData1=0xDEADBEEF in the same cycle (bypass). Next cycle with regW=0 → still 0xDEADBEEF (stored).
- regW=1, writeReg=0, writeData=0x12345678; resv=1, resvReg=0 → readData1 (readReg1=0) stays 0 and busy1=0 in that cycle and after.
- Scoreboard sequence:
  - resv=1, resvReg=7 → next cycle busy1=1 with readReg1=7.
  - Then regW=1, writeReg=7, writeData=0xA5 → busy1=0 and readData1=0xA5 in the same cycle.
  - Next cycle: pend[7]=0.
- Simultaneous resv=1, resvReg=9 and regW=1, writeReg=9 → next cycle busy2=1 with readReg2=9 and regW=0.
- Mid-run reset:
  - Setup: write 0xFF to reg 3, reserve reg 4.
  - Assert rst for 1 cycle; during CLEAR drive regW=1, writeReg=3, writeData=0x11 → ignored.
  - After ready=1: readData1 for reg 3 = 0, busy for reg 4 = 0.
- Parameter variant DATA_W=16, ADDR_W=3, ZERO_REG=0:
  - ready after 8 cycles.
  - Write 0xBEEF to reg 0 → reads back 0xBEEF.
